// File: rtl/add_multiply_xor_pkg.sv
// Shared types and constants for the pipelined add/multiply/xor inverter.
// A stage payload travels through every pipeline register of the block.
package add_multiply_xor_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int NEWTON_ITERS  = 3;
  localparam int LATENCY       = 6;

  typedef logic [WIDTH_DEFAULT-1:0] word_t;

  typedef struct packed {
    logic  valid;
    word_t t;
    word_t x;
    word_t b;
    word_t c;
    logic  err;
  } stage_t;

  // One Newton refinement of the inverse estimate x of c: x * (2 - c*x) mod 2^W.
  function automatic word_t newton_step(input word_t x, input word_t c);
    word_t cx;
    cx = c * x;
    return x * (word_t'(2) - cx);
  endfunction

endpackage

// File: rtl/newton_inv_step.sv
// One registered Newton stage: refines the inverse estimate carried in the payload.
// The whole payload freezes while hold is high.
module newton_inv_step
  import add_multiply_xor_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  input  stage_t stage_in,
  output stage_t stage_out
);

  stage_t stage_d;
  stage_t stage_q;

  always_comb begin
    stage_d   = stage_in;
    stage_d.x = newton_step(stage_in.x, stage_in.c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q.valid <= 1'b0;
    end else if (!hold) begin
      stage_q <= stage_d;
    end
  end

  assign stage_out = stage_q;

endmodule

// File: rtl/pipelined_add_multiply_xor_invert.sv
// Six-stage pipeline recovering a from y = ((a+b)*c) ^ d mod 2^16.
// The inverse of c is obtained by three Newton steps seeded with c itself.
module pipelined_add_multiply_xor_invert
  import add_multiply_xor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic             inv_err
);

  logic   stall;
  stage_t s1_d, s1_q;
  stage_t s2_q, s3_q, s4_q;
  stage_t s5_d, s5_q;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] a_out_d, a_out_q;
  logic             inv_err_d, inv_err_q;

  // Reset overrides the stall so the source is never blocked during reset.
  assign stall    = out_valid_q && !out_ready && !rst;
  assign in_ready = !stall;

  always_comb begin
    s1_d.valid = in_valid;
    s1_d.t     = y ^ d;
    s1_d.x     = c;
    s1_d.b     = b;
    s1_d.c     = c;
    s1_d.err   = ~c[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q.valid <= 1'b0;
    end else if (!stall) begin
      s1_q <= s1_d;
    end
  end

  newton_inv_step u_newton1 (.clk(clk), .rst(rst), .hold(stall), .stage_in(s1_q), .stage_out(s2_q));
  newton_inv_step u_newton2 (.clk(clk), .rst(rst), .hold(stall), .stage_in(s2_q), .stage_out(s3_q));
  newton_inv_step u_newton3 (.clk(clk), .rst(rst), .hold(stall), .stage_in(s3_q), .stage_out(s4_q));

  always_comb begin
    s5_d   = s4_q;
    s5_d.t = s4_q.t * s4_q.x;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s5_q.valid <= 1'b0;
    end else if (!stall) begin
      s5_q <= s5_d;
    end
  end

  // An even c has no inverse, so its result is forced to zero and flagged.
  always_comb begin
    out_valid_d = s5_q.valid;
    inv_err_d   = s5_q.err;
    a_out_d     = s5_q.err ? '0 : s5_q.t - s5_q.b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      a_out_q     <= '0;
      inv_err_q   <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= out_valid_d;
      a_out_q     <= a_out_d;
      inv_err_q   <= inv_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign a_out     = a_out_q;
  assign inv_err   = inv_err_q;

endmodule

// File: tb/tb_pipelined_add_multiply_xor_invert.sv
// Self-checking bench: random operands are encoded by the bench, so the expected
// a_out is simply the operand a that was chosen before encoding.
module tb_pipelined_add_multiply_xor_invert;
  import add_multiply_xor_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] y, b, c, d;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] a_out;
  logic        inv_err;

  int checks   = 0;
  int failures = 0;

  pipelined_add_multiply_xor_invert #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .b(b), .c(c), .d(d),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .inv_err(inv_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] encode(input logic [15:0] a, input logic [15:0] bb,
                                         input logic [15:0] cc, input logic [15:0] dd);
    logic [15:0] s;
    s = a + bb;
    s = s * cc;
    return s ^ dd;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    y = '0; b = '0; c = '0; d = '0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (a_out !== 16'h0) begin failures++; $display("[TB] FAIL reset_a_out: got %h expected 0000", a_out); end
    checks++; if (inv_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_inv_err: got %b expected 0", inv_err); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready_during: got %b expected 1", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready_after: got %b expected 1", in_ready); end
  endtask

  task automatic test_single_beat(input string name, input logic [15:0] yy, input logic [15:0] bb,
                                  input logic [15:0] cc, input logic [15:0] dd,
                                  input logic [15:0] exp_a, input logic exp_err);
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1; y = yy; b = bb; c = cc; d = dd;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checks++; if (lat !== LATENCY) begin failures++; $display("[TB] FAIL %s_latency: got %0d expected %0d", name, lat, LATENCY); end
    checks++; if (a_out !== exp_a) begin failures++; $display("[TB] FAIL %s_a_out: got %h expected %h", name, a_out, exp_a); end
    checks++; if (inv_err !== exp_err) begin failures++; $display("[TB] FAIL %s_inv_err: got %b expected %b", name, inv_err, exp_err); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL %s_single_result: got out_valid %b expected 0", name, out_valid); end
  endtask

  task automatic test_even_c();
    logic [15:0] ea [3];
    logic        ee [3];
    logic [15:0] av, bv, cv, dv;
    int n = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      av = 16'($urandom); bv = 16'($urandom); dv = 16'($urandom);
      cv = (i == 1) ? 16'h0002 : (16'($urandom) | 16'h0001);
      in_valid = 1'b1; b = bv; c = cv; d = dv; y = encode(av, bv, cv, dv);
      ea[i] = (i == 1) ? 16'h0000 : av;
      ee[i] = (i == 1);
      tick();
    end
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid) begin
        if (n < 3) begin
          checks++; if (a_out !== ea[n]) begin failures++; $display("[TB] FAIL even_c_a_out[%0d]: got %h expected %h", n, a_out, ea[n]); end
          checks++; if (inv_err !== ee[n]) begin failures++; $display("[TB] FAIL even_c_inv_err[%0d]: got %b expected %b", n, inv_err, ee[n]); end
        end
        n++;
      end
      tick();
    end
    checks++; if (n !== 3) begin failures++; $display("[TB] FAIL even_c_count: got %0d expected 3", n); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] av [20];
    logic [15:0] bv [20];
    logic [15:0] cv [20];
    logic [15:0] dv [20];
    int k = 0, r = 0, i = 0;
    logic prev_stall = 1'b0;
    logic [15:0] prev_a = '0;
    logic prev_err = 1'b0;
    logic exp_ready;
    for (int j = 0; j < 20; j++) begin
      av[j] = 16'($urandom); bv[j] = 16'($urandom);
      cv[j] = 16'($urandom) | 16'h0001; dv[j] = 16'($urandom);
    end
    while (r < 20 && i < 100) begin
      out_ready = !(i >= 8 && i <= 11);
      if (k < 20) begin
        in_valid = 1'b1; b = bv[k]; c = cv[k]; d = dv[k];
        y = encode(av[k], bv[k], cv[k], dv[k]);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_ready = !(i >= 8 && i <= 11);
      checks++; if (in_ready !== exp_ready) begin failures++; $display("[TB] FAIL b2b_in_ready cycle %0d: got %b expected %b", i, in_ready, exp_ready); end
      if (prev_stall) begin
        checks++; if (out_valid !== 1'b1 || a_out !== prev_a || inv_err !== prev_err) begin
          failures++;
          $display("[TB] FAIL b2b_hold cycle %0d: got v=%b a=%h e=%b expected v=1 a=%h e=%b", i, out_valid, a_out, inv_err, prev_a, prev_err);
        end
      end
      if (out_valid && out_ready) begin
        if (r < k) begin
          checks++; if (a_out !== av[r] || inv_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_result[%0d]: got a=%h e=%b expected a=%h e=0", r, a_out, inv_err, av[r]);
          end
        end else begin
          checks++; failures++;
          $display("[TB] FAIL b2b_extra_result: got result %0d with only %0d accepted", r, k);
        end
        r++;
      end
      prev_stall = out_valid && !out_ready;
      prev_a = a_out;
      prev_err = inv_err;
      if (in_valid && in_ready) k++;
      tick();
      i++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (r !== 20) begin failures++; $display("[TB] FAIL b2b_retired: got %0d expected 20", r); end
    checks++; if (k !== 20) begin failures++; $display("[TB] FAIL b2b_accepted: got %0d expected 20", k); end
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_duplicate: got out_valid %b expected 0", out_valid); end
    tick();
  endtask

  task automatic test_reset_flush();
    logic [15:0] av, bv, cv, dv;
    int emitted = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      av = 16'($urandom); bv = 16'($urandom); cv = 16'($urandom) | 16'h0001; dv = 16'($urandom);
      in_valid = 1'b1; b = bv; c = cv; d = dv; y = encode(av, bv, cv, dv);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid); end
    av = 16'($urandom); bv = 16'($urandom); cv = 16'($urandom) | 16'h0001; dv = 16'($urandom);
    in_valid = 1'b1; b = bv; c = cv; d = dv; y = encode(av, bv, cv, dv);
    tick();
    in_valid = 1'b0;
    for (int lat = 1; lat <= 15; lat++) begin
      if (out_valid) begin
        emitted++;
        checks++; if (lat !== LATENCY) begin failures++; $display("[TB] FAIL flush_stale_beat: got out_valid at cycle %0d expected only at %0d", lat, LATENCY); end
        checks++; if (a_out !== av) begin failures++; $display("[TB] FAIL flush_a_out: got %h expected %h", a_out, av); end
      end
      tick();
    end
    checks++; if (emitted !== 1) begin failures++; $display("[TB] FAIL flush_count: got %0d expected 1", emitted); end
  endtask

  task automatic test_newton_random();
    logic [15:0] prod;
    int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10010; i++) begin
      if (i < 10000) begin
        in_valid = 1'b1;
        y = 16'($urandom); b = 16'($urandom); c = 16'($urandom) | 16'h0001; d = 16'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (dut.s4_q.valid) begin
        prod = dut.s4_q.x * dut.s4_q.c;
        checks++; if (prod !== 16'h0001) begin
          failures++;
          $display("[TB] FAIL newton_inverse: got x*c=%h for c=%h expected 0001", prod, dut.s4_q.c);
        end
        seen++;
      end
      tick();
    end
    checks++; if (seen !== 10000) begin failures++; $display("[TB] FAIL newton_count: got %0d expected 10000", seen); end
  endtask

  initial begin
    test_reset();
    test_single_beat("known_vector", 16'h00DC, 16'h0004, 16'h0005, 16'h00FF, 16'h0003, 1'b0);
    test_single_beat("subtract_wrap", 16'h0001, 16'h0002, 16'h0001, 16'h0000, 16'hFFFF, 1'b0);
    test_even_c();
    test_back_to_back();
    test_reset_flush();
    test_newton_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
